// File: rtl/pulse_meter_pkg.sv
// Shared types and defaults for the pulse_meter slice.
package pulse_meter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int unsigned CNT_W_DEFAULT = 16;

endpackage

// File: rtl/edge_detect.sv
// Rise/fall detector on an already-synchronous input.
// The history register resets to 1 so a level that is high at reset release is not seen as a rise.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    output logic rise,
    output logic fall
);

    logic sig_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sig_q <= 1'b1;
        end else begin
            sig_q <= sig_in;
        end
    end

    assign rise = sig_in & ~sig_q;
    assign fall = ~sig_in & sig_q;

endmodule

// File: rtl/pulse_meter.sv
// Measures high time and period of sig_in between rising edges.
// Each result is offered through a valid/ready holding register.
module pulse_meter
    import pulse_meter_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sig_in,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic             overflow,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             rise;
    logic             fall;
    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] p_cnt;
    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] p_next;
    logic [CNT_W-1:0] h_next;
    logic             publish;
    logic             pub_ovf;
    logic             sat;

    edge_detect u_edge (
        .clk    (clk),
        .reset  (reset),
        .sig_in (sig_in),
        .rise   (rise),
        .fall   (fall)
    );

    assign sat = (p_cnt == '1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            p_cnt <= '0;
            h_cnt <= '0;
        end else begin
            state <= state_next;
            p_cnt <= p_next;
            h_cnt <= h_next;
        end
    end

    always_comb begin
        state_next = state;
        p_next     = p_cnt;
        h_next     = h_cnt;
        publish    = 1'b0;
        pub_ovf    = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    p_next     = CNT_ONE;
                    h_next     = CNT_ONE;
                    state_next = HIGH;
                end
            end
            // A rise cannot occur here: sig_in has been 1 since entry.
            HIGH: begin
                if (sat) begin
                    publish    = 1'b1;
                    pub_ovf    = 1'b1;
                    state_next = IDLE;
                end else if (fall) begin
                    p_next     = p_cnt + CNT_ONE;
                    state_next = LOW;
                end else if (sig_in) begin
                    p_next = p_cnt + CNT_ONE;
                    h_next = h_cnt + CNT_ONE;
                end
            end
            LOW: begin
                if (rise) begin
                    publish    = 1'b1;
                    p_next     = CNT_ONE;
                    h_next     = CNT_ONE;
                    state_next = HIGH;
                end else if (sat) begin
                    publish    = 1'b1;
                    pub_ovf    = 1'b1;
                    state_next = IDLE;
                end else begin
                    p_next = p_cnt + CNT_ONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meas_valid <= 1'b0;
            high_cnt   <= '0;
            period_cnt <= '0;
            overflow   <= 1'b0;
            overrun    <= 1'b0;
        end else if (publish) begin
            if (!meas_valid || meas_ready) begin
                meas_valid <= 1'b1;
                high_cnt   <= h_cnt;
                period_cnt <= p_cnt;
                overflow   <= pub_ovf;
            end else begin
                overrun <= 1'b1;
            end
        end else if (meas_valid && meas_ready) begin
            meas_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: a default-width instance and a 4-bit instance for saturation.
module tb_pulse_meter;

    logic        clk = 1'b0;
    logic        reset;
    logic        sig_in;
    logic        meas_ready;
    logic        meas_valid;
    logic [15:0] high_cnt;
    logic [15:0] period_cnt;
    logic        overflow;
    logic        overrun;

    logic        sig4;
    logic        ready4;
    logic        valid4;
    logic [3:0]  high4;
    logic [3:0]  period4;
    logic        ovf4;
    logic        ovr4;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    pulse_meter dut (
        .clk        (clk),
        .reset      (reset),
        .sig_in     (sig_in),
        .meas_valid (meas_valid),
        .meas_ready (meas_ready),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .overflow   (overflow),
        .overrun    (overrun)
    );

    pulse_meter #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .reset      (reset),
        .sig_in     (sig4),
        .meas_valid (valid4),
        .meas_ready (ready4),
        .high_cnt   (high4),
        .period_cnt (period4),
        .overflow   (ovf4),
        .overrun    (ovr4)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic s);
        sig_in = s;
        tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_res(input string tag, input logic v, input int unsigned h,
                             input int unsigned p, input logic o);
        check({tag, "_valid"}, 32'(meas_valid), 32'(v));
        check({tag, "_high"},  32'(high_cnt),   h);
        check({tag, "_period"}, 32'(period_cnt), p);
        check({tag, "_ovf"},   32'(overflow),   32'(o));
    endtask

    initial begin
        reset = 1'b1; sig_in = 1'b1; meas_ready = 1'b0;
        sig4 = 1'b0; ready4 = 1'b1;
        tick(); tick();
        check_res("reset", 1'b0, 0, 0, 1'b0);
        check("reset_overrun", 32'(overrun), 32'd0);
        check("reset4_valid", 32'(valid4), 32'd0);
        check("reset4_high", 32'(high4), 32'd0);

        // sig_in high through reset release: no rise, no result
        reset = 1'b0;
        repeat (5) step(1'b1);
        check("hold_high_valid", 32'(meas_valid), 32'd0);
        repeat (3) step(1'b0);
        check("hold_low_valid", 32'(meas_valid), 32'd0);
        check("stuck0_valid4", 32'(valid4), 32'd0);

        // basic 3 high / 5 low
        meas_ready = 1'b1;
        step(1'b1);
        check("basic_first_rise", 32'(meas_valid), 32'd0);
        repeat (2) step(1'b1);
        repeat (5) step(1'b0);
        check("basic_before_rise", 32'(meas_valid), 32'd0);
        step(1'b1);
        check_res("basic1", 1'b1, 3, 8, 1'b0);
        step(1'b1);
        check("basic_accepted", 32'(meas_valid), 32'd0);
        check("basic_hold_high", 32'(high_cnt), 32'd3);
        step(1'b1);
        repeat (5) step(1'b0);
        check("basic_gap", 32'(meas_valid), 32'd0);
        step(1'b1);
        check_res("basic2", 1'b1, 3, 8, 1'b0);

        // divided clock, toggle every 2 cycles
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            step(1'b0);
            step(1'b0);
            step(1'b1);
            check_res("div2", 1'b1, 2, 4, 1'b0);
        end

        // toggle every cycle
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check("div1_gap", 32'(meas_valid), 32'd0);
            step(1'b1);
            check_res("div1", 1'b1, 1, 2, 1'b0);
        end

        // back-pressure: 3/8 result held while a 2/6 period is dropped
        repeat (2) step(1'b1);
        repeat (5) step(1'b0);
        meas_ready = 1'b0;
        step(1'b1);
        check_res("bp_first", 1'b1, 3, 8, 1'b0);
        check("bp_overrun0", 32'(overrun), 32'd0);
        step(1'b1);
        repeat (4) step(1'b0);
        check_res("bp_held", 1'b1, 3, 8, 1'b0);
        check("bp_overrun_pre", 32'(overrun), 32'd0);
        step(1'b1);
        check_res("bp_drop", 1'b1, 3, 8, 1'b0);
        check("bp_overrun", 32'(overrun), 32'd1);
        meas_ready = 1'b1;
        step(1'b1);
        check("bp_consumed", 32'(meas_valid), 32'd0);
        check("bp_sticky", 32'(overrun), 32'd1);

        // accept/publish collision
        meas_ready = 1'b0;
        repeat (3) step(1'b0);
        step(1'b1);
        check_res("col_first", 1'b1, 2, 5, 1'b0);
        repeat (3) step(1'b0);
        check("col_waiting", 32'(meas_valid), 32'd1);
        meas_ready = 1'b1;
        step(1'b1);
        check_res("col_new", 1'b1, 1, 4, 1'b0);
        check("col_sticky", 32'(overrun), 32'd1);

        // reset mid-LOW with a pending result
        meas_ready = 1'b0;
        step(1'b0);
        step(1'b0);
        reset = 1'b1;
        tick();
        check_res("rst_mid", 1'b0, 0, 0, 1'b0);
        check("rst_mid_overrun", 32'(overrun), 32'd0);
        reset = 1'b0;
        meas_ready = 1'b1;
        step(1'b0);
        step(1'b1);
        repeat (2) step(1'b1);
        repeat (5) step(1'b0);
        check("rst_no_result", 32'(meas_valid), 32'd0);
        step(1'b1);
        check_res("rst_after", 1'b1, 3, 8, 1'b0);

        // saturation on the 4-bit instance
        sig4 = 1'b1;
        tick();
        repeat (14) tick();
        check("sat_pre_valid", 32'(valid4), 32'd0);
        tick();
        check("sat_valid", 32'(valid4), 32'd1);
        check("sat_high", 32'(high4), 32'd15);
        check("sat_period", 32'(period4), 32'd15);
        check("sat_ovf", 32'(ovf4), 32'd1);
        repeat (20) tick();
        check("sat_idle_valid", 32'(valid4), 32'd0);
        sig4 = 1'b0;
        repeat (3) tick();
        check("sat_idle_fall", 32'(valid4), 32'd0);
        sig4 = 1'b1; tick();
        sig4 = 1'b0; tick(); tick();
        sig4 = 1'b1; tick();
        check("fresh_valid", 32'(valid4), 32'd1);
        check("fresh_high", 32'(high4), 32'd1);
        check("fresh_period", 32'(period4), 32'd3);
        check("fresh_ovf", 32'(ovf4), 32'd0);
        check("fresh_overrun", 32'(ovr4), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
